// File: rtl/sdram_report_pkg.sv
// sdram_report_pkg: shared state encoding, message constants and hex helper for the status UART
package sdram_report_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, FIN} state_t;
  localparam int MSG_LEN = 23;
  localparam logic [7:0] ASC_P  = 8'h50;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_EQ = 8'h3D;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter that can accept the next byte on the final stop-bit edge.
//  clk, reset : clock, asynchronous active-high reset
//  load       : take data when ready is high
//  data       : byte to send, LSB first
//  ready      : idle, or on the last cycle of a stop bit (allows gapless back-to-back bytes)
//  txd        : serial output, idle high
module uart_tx_byte
  import sdram_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
  state_t      st, st_nx;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  sh;
  logic        tick;
  assign tick  = cnt == 16'd0;
  assign ready = st == IDLE || (st == STOP && tick);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else st <= st_nx;
  end
  always_comb begin
    st_nx = st;
    if (load && ready) st_nx = START;
    else if (tick)
      st_nx = st == START ? DATA :
              st == DATA  ? (bitn == 3'd7 ? STOP : DATA) :
              st == STOP  ? IDLE : st;
  end
  always_comb txd = st == START ? 1'b0 : st == DATA ? sh[0] : 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 16'd0;
      bitn <= 3'd0;
      sh   <= 8'd0;
    end else if (load && ready) begin
      cnt  <= RELOAD;
      bitn <= 3'd0;
      sh   <= data;
    end else if (st != IDLE) begin
      cnt <= tick ? (st == STOP ? 16'd0 : RELOAD) : cnt - 16'd1;
      if (tick && st == DATA) begin
        sh   <= sh >> 1;
        bitn <= bitn + 3'd1;
      end
    end
  end
endmodule

// File: rtl/sdram_status_uart.sv
// sdram_status_uart: sends "P=hhhhhhhh E=hhhhhhhh\r\n" over 8N1 UART on each accepted report strobe.
//  clk, reset     : system clock, asynchronous active-high reset
//  report_strobe  : start a report (accepted only when idle); snapshots both counters
//  pass_count     : tester pass counter
//  error_count    : tester error counter
//  busy           : high from acceptance until the last stop bit completes
//  done           : one-cycle pulse after the last stop bit
//  txd            : UART serial output, idle high
module sdram_status_uart
  import sdram_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        report_strobe,
  input  logic [31:0] pass_count,
  input  logic [31:0] error_count,
  output logic        busy,
  output logic        done,
  output logic        txd
);
  localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);
  state_t      st, st_nx;
  logic [4:0]  idx, off;
  logic [31:0] pass_snap, err_snap, word;
  logic [3:0]  nib;
  logic [7:0]  ch;
  logic        load, ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else st <= st_nx;
  end
  // DATA feeds characters as the transmitter frees up; STOP drains the final character.
  always_comb begin
    st_nx = st;
    st_nx = (st == IDLE && report_strobe)           ? LOAD :
            st == LOAD                              ? DATA :
            (st == DATA && ready && idx == LAST_IDX) ? STOP :
            (st == STOP && ready)                   ? FIN  :
            st == FIN                               ? IDLE : st;
  end
  always_comb begin
    busy = st == LOAD || st == DATA || st == STOP;
    done = st == FIN;
    load = st == DATA;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 5'd0;
      pass_snap <= 32'd0;
      err_snap  <= 32'd0;
    end else begin
      if (st == IDLE && report_strobe) begin
        pass_snap <= pass_count;
        err_snap  <= error_count;
      end
      if (st == LOAD) idx <= 5'd0;
      else if (st == DATA && ready) idx <= idx + 5'd1;
    end
  end
  // Nibble position counts down from 7 (MS nibble) at idx 2/13 to 0 at idx 9/20.
  always_comb begin
    word = idx < 5'd10 ? pass_snap : err_snap;
    off  = idx < 5'd10 ? 5'd9 - idx : 5'd20 - idx;
    nib  = word[{off[2:0], 2'b00} +: 4];
    ch   = idx == 5'd0                 ? ASC_P  :
           (idx == 5'd1 || idx == 5'd12) ? ASC_EQ :
           idx == 5'd10                ? ASC_SP :
           idx == 5'd11                ? ASC_E  :
           idx == 5'd21                ? ASC_CR :
           idx == 5'd22                ? ASC_LF : hex_ascii(nib);
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .data (ch),
    .ready(ready),
    .txd  (txd)
  );
endmodule

// File: tb/tb_sdram_status_uart.sv
// tb_sdram_status_uart: scoreboard bench with a mid-bit UART decoder checking report lines and timing
module tb_sdram_status_uart;
  localparam int CPB  = 4;
  localparam int LINE = 2 + 23 * 10 * CPB;
  logic        clk, reset, report_strobe, busy, done, txd;
  logic [31:0] pass_count, error_count;
  int          cyc = 0;
  int          n_pass = 0, n_total = 0;
  int          last_done = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];
  int          done_q[$];
  bit          in_line = 0;

  sdram_status_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .report_strobe(report_strobe),
    .pass_count   (pass_count),
    .error_count  (error_count),
    .busy         (busy),
    .done         (done),
    .txd          (txd)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference line: formatted text, uppercased, then CR LF.
  task automatic push_line(input logic [31:0] p, input logic [31:0] e, input int k);
    string s;
    s = $sformatf("P=%h E=%h", p, e);
    s = s.toupper();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    start_q.push_back(k + 3);
    done_q.push_back(k + 1 + LINE);
    last_done = k + 1 + LINE;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe high for one cycle starting at cycle k; sampled at edge k+1.
  task automatic strobe(input logic [31:0] p, input logic [31:0] e, input bit accept, output int k);
    @(posedge clk);
    #1;
    pass_count    = p;
    error_count   = e;
    report_strobe = 1;
    k = cyc;
    if (accept) push_line(p, e, k);
    @(posedge clk);
    #1;
    report_strobe = 0;
    if (accept) chk("busy_on_accept", busy, 1);
  endtask

  initial begin : decoder
    logic [9:0] bits;
    logic [3:0] smp;
    logic       ok, abort;
    int         c0;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        c0 = cyc;
        ok = 1;
        abort = 0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int s = 0; s < 4; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (reset) abort = 1;
            smp[s] = txd;
          end
          bits[b] = smp[2];
          if (smp !== {4{smp[2]}}) ok = 0;
        end
        if (abort) in_line = 0;
        else begin
          if (!in_line) begin
            chk("line_expected", start_q.size() != 0, 1);
            if (start_q.size() != 0) chk("start_cycle", c0, start_q.pop_front());
            in_line = 1;
          end
          chk("bit_width", ok, 1);
          chk("framing", {bits[9], bits[0]}, 2'b10);
          chk("char_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            eb = exp_q.pop_front();
            chk("char", bits[8:1], eb);
            if (eb == 8'h0A) in_line = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_expected", done_q.size() != 0, 1);
      if (done_q.size() != 0) chk("done_cycle", cyc, done_q.pop_front());
      chk("busy_low_at_done", busy, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, d;
    logic [31:0] p, e;
    reset = 1;
    report_strobe = 0;
    pass_count = 0;
    error_count = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {txd, busy, done}, 3'b100);
    reset = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk("idle_quiet", {txd, busy, done}, 3'b100);
    end
    strobe(32'h0000_0001, 32'hDEAD_BEEF, 1, k);
    wait_until(last_done + 3);
    p = $urandom;
    e = $urandom;
    strobe(p, e, 1, k);
    wait_until(k + 215);
    strobe(32'hFFFF_FFFF, e, 0, d);
    chk("busy_after_ignored", busy, 1);
    wait_until(last_done + 3);
    e = $urandom;
    strobe(32'hFFFF_FFFF, e, 1, k);
    d = last_done;
    wait_until(d);
    report_strobe = 1;
    chk("busy_in_done_cycle", busy, 0);
    @(posedge clk);
    #1;
    chk("strobe_on_done_ignored", busy, 0);
    p = $urandom;
    e = $urandom;
    pass_count = p;
    error_count = e;
    push_line(p, e, cyc);
    @(posedge clk);
    #1;
    report_strobe = 0;
    chk("strobe_after_done_accepted", busy, 1);
    wait_until(last_done + 3);
    strobe($urandom, $urandom, 1, k);
    wait_until(k + 301);
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("reset_midline", {txd, busy, done}, 3'b100);
    exp_q.delete();
    start_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    repeat (10) @(posedge clk);
    #1;
    strobe($urandom, $urandom, 1, k);
    wait_until(last_done + 3);
    strobe(32'h0123_4567, 32'h89AB_CDEF, 1, k);
    wait_until(last_done + 3);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      strobe($urandom, $urandom, 1, k);
      wait_until(last_done + 2);
    end
    wait_until(last_done + 10);
    chk("leftover_expectations", exp_q.size() + start_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
